// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared constants and types for the AES-128 decryption datapath
package aes_dec_pkg;

  localparam int NR_128  = 10;
  localparam int STATE_W = 128;

  typedef logic [3:0]         rnd_t;
  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic {
    ARK_IDLE,
    ARK_ACTIVE
  } ark_state_e;

  typedef struct packed {
    state_t state;
    rnd_t   rnd;
    logic   mix;
    logic   last;
  } ark_beat_t;

  // Routing tags travel with the beat so they stay aligned with out_state.
  function automatic ark_beat_t make_beat(input state_t s, input rnd_t r, input int nr);
    ark_beat_t b;
    b.state = s;
    b.rnd   = r;
    b.mix   = (r != '0) && (r != rnd_t'(nr));
    b.last  = (r == '0);
    return b;
  endfunction

endpackage

// File: rtl/aes_round_key_file.sv
// rtl/aes_round_key_file.sv - round-key register file, one write port, async read, sync clear
module aes_round_key_file
  import aes_dec_pkg::*;
#(
  parameter int DEPTH = NR_128 + 1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   we_i,
  input  rnd_t   waddr_i,
  input  state_t wdata_i,
  input  rnd_t   raddr_i,
  output state_t rdata_o
);

  state_t key_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) key_q[i] <= '0;
    end else if (we_i && (int'(waddr_i) < DEPTH)) begin
      key_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle write and read of one index returns the old key.
  assign rdata_o = (int'(raddr_i) < DEPTH) ? key_q[raddr_i] : '0;

endmodule

// File: rtl/inv_add_round_key_stage.sv
// rtl/inv_add_round_key_stage.sv - AES-128 decrypt AddRoundKey stage with round tracking
// AES_ARK_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module inv_add_round_key_stage
  import aes_dec_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_we,
  input  logic [3:0]   key_addr,
  input  logic [127:0] key_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_mix,
  output logic         out_last,
  output logic         err
);

  ark_state_e st_q, st_d;
  rnd_t       rnd_q, rnd_d;
  logic       err_q, err_d;
  logic       accept, produce;
  rnd_t       key_idx;
  state_t     round_key;
  ark_beat_t  beat, head;

  assign accept = in_valid & in_ready;

  aes_round_key_file #(.DEPTH(NR + 1)) u_keys (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (key_we),
    .waddr_i (key_addr),
    .wdata_i (key_data),
    .raddr_i (key_idx),
    .rdata_o (round_key)
  );

  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    produce = 1'b0;
    err_d   = 1'b0;
    key_idx = in_first ? rnd_t'(NR) : rnd_q;
    if (accept) begin
      if (in_first) begin
        st_d    = ARK_ACTIVE;
        rnd_d   = rnd_t'(NR - 1);
        produce = 1'b1;
      end else if (st_q == ARK_ACTIVE) begin
        produce = 1'b1;
        if (rnd_q == '0) st_d = ARK_IDLE;
        else             rnd_d = rnd_q - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= ARK_IDLE;
      rnd_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      rnd_q <= rnd_d;
      err_q <= err_d;
    end
  end

  assign beat = make_beat(in_state ^ round_key, key_idx, NR);

`ifdef AES_ARK_SKID_EN
  ark_beat_t  skid_q [2];
  logic [1:0] cnt_q, cnt_d, wr_idx;
  logic       in_ready_q, pop;

  assign pop    = (cnt_q != 2'd0) && out_ready;
  assign wr_idx = cnt_q - 2'(pop);
  assign cnt_d  = cnt_q + 2'(produce) - 2'(pop);

  // Slot 0 is the head; a push into slot 0 overrides the shift from slot 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != 2'd2);
      if (pop)     skid_q[0]         <= skid_q[1];
      if (produce) skid_q[wr_idx[0]] <= beat;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign head      = skid_q[0];
`else
  ark_beat_t out_q;
  logic      out_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (produce) begin
      out_q       <= beat;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign head      = out_q;
`endif

  assign out_state = head.state;
  assign out_round = head.rnd;
  assign out_mix   = head.mix;
  assign out_last  = head.last;
  assign err       = err_q;

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// tb/tb_inv_add_round_key_stage.sv - self-checking bench with reference model and directed/random steps
module tb_inv_add_round_key_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, key_we, in_valid, in_first, out_ready;
  logic [3:0]   key_addr;
  logic [127:0] key_data, in_state;
  logic         in_ready, out_valid, out_mix, out_last, err;
  logic [127:0] out_state;
  logic [3:0]   out_round;

  inv_add_round_key_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_data  (key_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_mix   (out_mix),
    .out_last  (out_last),
    .err       (err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] st;
    int           rnd;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] keys_m [11];
  int           m_rnd;
  bit           err_exp;
  int           mixes;
  logic [127:0] v;

  logic [127:0] fips [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 11; i++) keys_m[i] = '0;
    m_rnd   = -1;
    err_exp = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_out_round", out_round, 0);
    chk("rst_out_mix", out_mix, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // One clock: compare outputs to the model at negedge, then advance the model
  // by what happens at the coming rising edge.
  task automatic cycle();
    bit   acc;
    exp_t e;
    @(negedge clk);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_state", out_state, exp_q[0].st);
      chk("out_round", out_round, exp_q[0].rnd);
      chk("out_mix", out_mix, (exp_q[0].rnd != 0) && (exp_q[0].rnd != 10));
      chk("out_last", out_last, exp_q[0].rnd == 0);
    end
    chk("err", err, err_exp);
`ifdef AES_ARK_SKID_EN
    chk("in_ready", in_ready, exp_q.size() < 2);
`else
    chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
`endif
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = in_valid && in_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      err_exp = 1'b0;
      if (acc) begin
        if (in_first) begin
          e.st = in_state ^ keys_m[10]; e.rnd = 10;
          exp_q.push_back(e);
          m_rnd = 9;
        end else if (m_rnd >= 0) begin
          e.st = in_state ^ keys_m[m_rnd]; e.rnd = m_rnd;
          exp_q.push_back(e);
          m_rnd--;
        end else begin
          err_exp = 1'b1;
        end
      end
      if (key_we && key_addr <= 4'd10) keys_m[key_addr] = key_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit first, input logic [127:0] st);
    in_valid = 1'b1; in_first = first; in_state = st;
    cycle();
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_reset();
  endtask

  initial begin
    rst_n = 1'b0; key_we = 1'b0; key_addr = '0; key_data = '0;
    in_valid = 1'b0; in_first = 1'b0; in_state = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;

    // FIPS-197 schedule, plus writes above NR that must be ignored
    for (int i = 0; i < 11; i++) begin
      key_we = 1'b1; key_addr = 4'(i); key_data = fips[i];
      cycle();
    end
    for (int a = 11; a < 16; a++) begin
      key_addr = 4'(a); key_data = rnd128();
      cycle();
    end
    key_we = 1'b0;

    send(1'b1, 128'h3925841d02dc09fbdc118597196a0b32);
    chk("fips_r10_state", out_state, 128'he9317db5cb322c723d2e895faf090794);
    chk("fips_r10_round", out_round, 10);
    chk("fips_r10_mix", out_mix, 0);
    chk("fips_r10_last", out_last, 0);
    for (int i = 0; i < 9; i++) send(1'b0, rnd128());
    send(1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("fips_r0_state", out_state, 128'h3243f6a8885a308d313198a2e0370734);
    chk("fips_r0_last", out_last, 1);
    cycle();

    // Reset clears the key file: zero keys pass the state through
    do_reset();
    mixes = 0;
    for (int i = 0; i < 11; i++) begin
      v = {$urandom(), $urandom(), $urandom(), 32'(i)};
      send(i == 0, v);
      chk("zero_key_pass", out_state, v);
      chk("zero_key_round", out_round, 10 - i);
      if (out_valid && out_mix) mixes++;
    end
    chk("mix_count", mixes, 9);
    cycle();

    // Follow-on beat while idle: dropped, one-cycle err
    send(1'b0, rnd128());
    chk("idle_drop_valid", out_valid, 0);
    chk("idle_err_pulse", err, 1);
    cycle();
    chk("idle_err_clear", err, 0);

    // in_first mid-block restarts the count
    send(1'b1, rnd128());
    for (int i = 0; i < 3; i++) send(1'b0, rnd128());
    send(1'b1, rnd128());
    chk("restart_round", out_round, 10);
    send(1'b0, rnd128());
    chk("restart_next", out_round, 9);
    cycle();

    // Backpressure: out_ready low for 5 cycles while in_valid stays high
    key_we = 1'b1;
    for (int i = 0; i < 11; i++) begin
      key_addr = 4'(i); key_data = rnd128();
      cycle();
    end
    key_we = 1'b0;
    send(1'b1, rnd128());
    in_valid = 1'b1; in_first = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_state = rnd128();
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40 && m_rnd >= 0; i++) begin
      in_state = rnd128();
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("drain_valid", out_valid, 0);

    // Reset asserted while the round-5 beat is presented
    send(1'b1, rnd128());
    for (int i = 0; i < 4; i++) send(1'b0, rnd128());
    in_valid = 1'b1; in_state = rnd128();
    do_reset();
    in_valid = 1'b0;
    v = rnd128();
    send(1'b1, v);
    chk("post_rst_round", out_round, 10);
    chk("post_rst_state", out_state, v);
    cycle();

    // Random traffic with concurrent key writes and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_first  = ($urandom_range(0, 5) == 0);
      in_state  = rnd128();
      out_ready = ($urandom_range(0, 2) != 0);
      key_we    = ($urandom_range(0, 3) == 0);
      key_addr  = 4'($urandom_range(0, 15));
      key_data  = rnd128();
      cycle();
    end
    in_valid = 1'b0; key_we = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_drain", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
